// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle main control unit: states, opcodes,
// control-word layout and the field encodings the datapath's ALU control also uses.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StExecI   = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StIllegal = 4'd10
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    localparam int unsigned CW_PC_WRITE       = 15;
    localparam int unsigned CW_PC_WRITE_COND  = 14;
    localparam int unsigned CW_IOR_D          = 13;
    localparam int unsigned CW_MEM_READ       = 12;
    localparam int unsigned CW_MEM_WRITE      = 11;
    localparam int unsigned CW_IR_WRITE       = 10;
    localparam int unsigned CW_MEM_TO_REG     = 9;
    localparam int unsigned CW_PC_SOURCE_LSB  = 7;
    localparam int unsigned CW_ALU_OP_LSB     = 5;
    localparam int unsigned CW_ALU_SRC_B_LSB  = 3;
    localparam int unsigned CW_ALU_SRC_A      = 2;
    localparam int unsigned CW_REG_WRITE      = 1;
    localparam int unsigned CW_REG_DST        = 0;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_SUB    = 2'b01;
    localparam logic [1:0] ALU_OP_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_IFUNCT = 2'b11;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH1 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

    localparam logic [15:0] CW_FETCH   = 16'h9408;
    localparam logic [15:0] CW_DECODE  = 16'h0018;
    localparam logic [15:0] CW_MEMADR  = 16'h0014;
    localparam logic [15:0] CW_MEMRD   = 16'h3000;
    localparam logic [15:0] CW_MEMWB   = 16'h0202;
    localparam logic [15:0] CW_MEMWR   = 16'h2800;
    localparam logic [15:0] CW_EXEC_R  = 16'h0044;
    localparam logic [15:0] CW_EXEC_I  = 16'h0074;
    localparam logic [15:0] CW_ALUWB   = 16'h0002;
    localparam logic [15:0] CW_BRANCH  = 16'h40A4;
    localparam logic [15:0] CW_ILLEGAL = 16'h0000;

    function automatic logic [15:0] cw_of_state(input state_e st);
        case (st)
            StFetch:  return CW_FETCH;
            StDecode: return CW_DECODE;
            StMemAdr: return CW_MEMADR;
            StMemRd:  return CW_MEMRD;
            StMemWb:  return CW_MEMWB;
            StMemWr:  return CW_MEMWR;
            StExecR:  return CW_EXEC_R;
            StExecI:  return CW_EXEC_I;
            StAluWb:  return CW_ALUWB;
            StBranch: return CW_BRANCH;
            default:  return CW_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle main control FSM: sequences per-cycle control words for the datapath,
// stalling fetch and memory states on the memory ready handshake.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  Opcode,
    input  logic        mem_ready,
    output logic [15:0] Control_word,
    output logic [3:0]  state,
    output logic        instr_retired,
    output logic        illegal
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mem_rdy;

    assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            StFetch:  if (mem_rdy) state_d = StDecode;
            StDecode: begin
                case (Opcode)
                    OP_LOAD, OP_STORE: state_d = StMemAdr;
                    OP_RTYPE:          state_d = StExecR;
                    OP_ITYPE:          state_d = StExecI;
                    OP_BRANCH:         state_d = StBranch;
                    default: begin
                        state_d   = StIllegal;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: state_d = (Opcode == OP_STORE) ? StMemWr : StMemRd;
            StMemRd:  if (mem_rdy) state_d = StMemWb;
            StMemWr:  if (mem_rdy) state_d = StFetch;
            StExecR,
            StExecI:  state_d = StAluWb;
            StAluWb,
            StMemWb,
            StBranch: state_d = StFetch;
            StIllegal: state_d = StIllegal;
            // Unused encodings park in the terminal trap rather than run wild.
            default:  state_d = StIllegal;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Mealy outputs: a fetch stall must not advance PC or overwrite IR.
    always_comb begin
        Control_word  = 16'h0000;
        instr_retired = 1'b0;
        if (!reset) begin
            Control_word = cw_of_state(state_q);
            if (state_q == StFetch && !mem_rdy) begin
                Control_word[CW_PC_WRITE] = 1'b0;
                Control_word[CW_IR_WRITE] = 1'b0;
            end
            instr_retired = (state_q == StMemWb) || (state_q == StAluWb) ||
                            (state_q == StBranch) || (state_q == StMemWr && mem_rdy);
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench: each instruction's expected cycle-by-cycle
// control words are built from the opcode and the chosen memory wait counts.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  Opcode = 7'h00;
    logic        mem_ready = 1'b1;
    logic [15:0] Control_word;
    logic [3:0]  state;
    logic        instr_retired;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] e_cw[$];
    logic        e_ret[$];
    logic        e_mr[$];
    logic [6:0]  e_op[$];

    mc_control_fsm #(.USE_MEM_READY(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .Opcode        (Opcode),
        .mem_ready     (mem_ready),
        .Control_word  (Control_word),
        .state         (state),
        .instr_retired (instr_retired),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a rising edge; return at the falling edge for sampling.
    task automatic cyc(input logic r, input logic m, input logic [6:0] o);
        @(posedge clk);
        #1;
        reset     = r;
        mem_ready = m;
        Opcode    = o;
        @(negedge clk);
    endtask

    task automatic add(input logic [15:0] cw, input logic ret, input logic mr,
                       input logic [6:0] op);
        e_cw.push_back(cw);
        e_ret.push_back(ret);
        e_mr.push_back(mr);
        e_op.push_back(op);
    endtask

    // Reference: a legal instruction is fetch (with stalls), decode, then its type's tail.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
        e_cw.delete(); e_ret.delete(); e_mr.delete(); e_op.delete();
        for (int i = 0; i < fw; i++) add(16'h1008, 1'b0, 1'b0, 7'($urandom));
        add(16'h9408, 1'b0, 1'b1, 7'($urandom));
        add(16'h0018, 1'b0, 1'($urandom), op);
        case (op)
            7'h33: begin
                add(16'h0044, 1'b0, 1'($urandom), op);
                add(16'h0002, 1'b1, 1'($urandom), op);
            end
            7'h13: begin
                add(16'h0074, 1'b0, 1'($urandom), op);
                add(16'h0002, 1'b1, 1'($urandom), op);
            end
            7'h63: add(16'h40A4, 1'b1, 1'($urandom), op);
            7'h03: begin
                add(16'h0014, 1'b0, 1'($urandom), op);
                for (int i = 0; i < mw; i++) add(16'h3000, 1'b0, 1'b0, op);
                add(16'h3000, 1'b0, 1'b1, op);
                add(16'h0202, 1'b1, 1'($urandom), op);
            end
            default: begin
                add(16'h0014, 1'b0, 1'($urandom), op);
                for (int i = 0; i < mw; i++) add(16'h2800, 1'b0, 1'b0, op);
                add(16'h2800, 1'b1, 1'b1, op);
            end
        endcase
        for (int i = 0; i < e_cw.size(); i++) begin
            cyc(1'b0, e_mr[i], e_op[i]);
            chk($sformatf("cw op=%02h c%0d", op, i), 32'(Control_word), 32'(e_cw[i]));
            chk($sformatf("ret op=%02h c%0d", op, i), 32'(instr_retired), 32'(e_ret[i]));
            chk($sformatf("illegal op=%02h c%0d", op, i), 32'(illegal), 32'd0);
            if (i == 0) chk("state at fetch", 32'(state), 32'(StFetch));
        end
    endtask

    initial begin
        logic [6:0] ops [5];
        ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13; ops[4] = 7'h63;

        // Reset held three cycles with mem_ready high: all strobes suppressed.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 7'h00);
            chk("reset cw", 32'(Control_word), 32'h0000);
            chk("reset ret", 32'(instr_retired), 32'd0);
        end
        chk("reset illegal", 32'(illegal), 32'd0);
        chk("reset state", 32'(state), 32'(StFetch));

        // Directed: R-type, load with waits, store then branch back to back.
        run_instr(7'h33, 0, 0);
        run_instr(7'h03, 2, 1);
        run_instr(7'h23, 0, 0);
        run_instr(7'h63, 0, 0);

        for (int n = 0; n < 60; n++)
            run_instr(ops[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom_range(0, 3));

        // Reset while a store is waiting on memory: memWrite must drop immediately.
        cyc(1'b0, 1'b1, 7'h23);
        chk("sd fetch", 32'(Control_word), 32'h9408);
        cyc(1'b0, 1'b1, 7'h23);
        cyc(1'b0, 1'b1, 7'h23);
        chk("sd memadr", 32'(Control_word), 32'h0014);
        cyc(1'b0, 1'b0, 7'h23);
        chk("sd wait", 32'(Control_word), 32'h2800);
        chk("sd wait ret", 32'(instr_retired), 32'd0);
        cyc(1'b1, 1'b0, 7'h23);
        chk("rst in wait cw", 32'(Control_word), 32'h0000);
        chk("rst in wait ret", 32'(instr_retired), 32'd0);
        cyc(1'b0, 1'b1, 7'h00);
        chk("resume cw", 32'(Control_word), 32'h9408);
        chk("resume state", 32'(state), 32'(StFetch));

        // Undefined opcode traps until reset.
        cyc(1'b0, 1'b1, 7'h7F);
        chk("ill decode cw", 32'(Control_word), 32'h0018);
        chk("ill decode flag", 32'(illegal), 32'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'($urandom), (i == 0) ? 7'h7F : 7'($urandom));
            chk($sformatf("ill cw %0d", i), 32'(Control_word), 32'h0000);
            chk($sformatf("ill flag %0d", i), 32'(illegal), 32'd1);
            chk($sformatf("ill ret %0d", i), 32'(instr_retired), 32'd0);
        end
        chk("ill state", 32'(state), 32'(StIllegal));
        cyc(1'b1, 1'b1, 7'h00);
        chk("ill reset cw", 32'(Control_word), 32'h0000);
        cyc(1'b0, 1'b1, 7'h00);
        chk("ill cleared", 32'(illegal), 32'd0);
        chk("ill fetch cw", 32'(Control_word), 32'h9408);
        cyc(1'b0, 1'b1, 7'h13);
        chk("post-ill decode", 32'(Control_word), 32'h0018);
        cyc(1'b0, 1'b1, 7'h13);
        chk("post-ill exec_i", 32'(Control_word), 32'h0074);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
